// File: rtl/ps2_keyboard_rx_if.sv
// Decoded-character stream from the PS/2 receiver to the LCD message writer.
interface ps2_keyboard_rx_if;
  logic [7:0] outASCIIData;
  logic       outWriteData;

  modport master (output outASCIIData, output outWriteData);
  modport slave  (input  outASCIIData, input  outWriteData);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter the clock, deframe, and
// translate Set 2 scan codes into ASCII and cursor/control codes.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                     inClock,
  input  logic                     inResetNeg,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DAT,
  ps2_keyboard_rx_if.master        kb,
  output logic [7:0]               outScanCode,
  output logic                     outFrameError
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall, dat_s;

  // Sync FFs and filtered clock reset high (bus idle) so release never fakes an edge.
  always_ff @(posedge inClock or negedge inResetNeg) begin
    if (!inResetNeg) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_filt_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      if (clk_sync_q[1] == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        clk_filt_q <= clk_sync_q[1];
        flt_cnt_q  <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  assign fall  = clk_filt_q & ~clk_sync_q[1] & (flt_cnt_q == FLT_LAST);
  assign dat_s = dat_sync_q[1];

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          frame_err_q;
  logic          frame_ok, byte_rdy;

  assign frame_ok = dat_s & (^shreg_q ^ par_q);
  assign byte_rdy = (state_q == S_STOP) & fall & frame_ok;

  always_ff @(posedge inClock or negedge inResetNeg) begin
    if (!inResetNeg) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_q <= '0;
        if (fall && !dat_s) begin
          state_q   <= S_DATA;
          bit_cnt_q <= '0;
        end
      end else if (tmo_q == TMO_LAST) begin
        state_q     <= S_IDLE;
        tmo_q       <= '0;
        frame_err_q <= 1'b1;
      end else begin
        tmo_q <= fall ? '0 : tmo_q + TW'(1);
        if (fall) begin
          case (state_q)
            S_DATA: begin
              shreg_q   <= {dat_s, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
            end
            S_PARITY: begin
              par_q   <= dat_s;
              state_q <= S_STOP;
            end
            S_STOP: begin
              frame_err_q <= ~frame_ok;
              state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Translation tables: lc/uc are the unshifted/shifted characters (0 = no output).
  logic [7:0] lc, uc, ext_ch;
  always_comb begin
    lc     = '0;
    uc     = '0;
    ext_ch = '0;
    case (shreg_q)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      8'h45: begin lc = "0"; uc = ")"; end
      8'h16: begin lc = "1"; uc = "!"; end
      8'h1E: begin lc = "2"; uc = "@"; end
      8'h26: begin lc = "3"; uc = "#"; end
      8'h25: begin lc = "4"; uc = "$"; end
      8'h2E: begin lc = "5"; uc = "%"; end
      8'h36: begin lc = "6"; uc = "^"; end
      8'h3D: begin lc = "7"; uc = "&"; end
      8'h3E: begin lc = "8"; uc = "*"; end
      8'h46: begin lc = "9"; uc = "("; end
      8'h4E: begin lc = "-"; uc = "_"; end
      8'h55: begin lc = "="; uc = "+"; end
      8'h41: begin lc = ","; uc = "<"; end
      8'h49: begin lc = "."; uc = ">"; end
      8'h4A: begin lc = "/"; uc = "?"; end
      8'h4C: begin lc = ";"; uc = ":"; end
      8'h52: begin lc = "'"; uc = "\""; end
      8'h5A: begin lc = 8'h0D; uc = 8'h0D; end
      8'h76: begin lc = 8'h1B; uc = 8'h1B; end
      8'h29: begin lc = 8'h20; uc = 8'h20; end
      default: ;
    endcase
    if (lc >= "a" && lc <= "z") uc = lc - 8'h20;
    case (shreg_q)
      8'h75: ext_ch = 8'h11;
      8'h72: ext_ch = 8'h12;
      8'h6B: ext_ch = 8'h13;
      8'h74: ext_ch = 8'h14;
      8'h5A: ext_ch = 8'h0D;
      default: ;
    endcase
  end

  logic       ext_q, brk_q, lshift_q, rshift_q;
  logic [7:0] ascii_q, scan_q;
  logic       wr_q;

  always_ff @(posedge inClock or negedge inResetNeg) begin
    if (!inResetNeg) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ascii_q  <= '0;
      scan_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
      if (byte_rdy) begin
        scan_q <= shreg_q;
        if (shreg_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shreg_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!ext_q && shreg_q == 8'h12) begin
            lshift_q <= ~brk_q;
          end else if (!ext_q && shreg_q == 8'h59) begin
            rshift_q <= ~brk_q;
          end else if (!brk_q && ext_q && ext_ch != 8'h00) begin
            ascii_q <= ext_ch;
            wr_q    <= 1'b1;
          end else if (!brk_q && !ext_q && lc != 8'h00) begin
            ascii_q <= (lshift_q | rshift_q) ? uc : lc;
            wr_q    <= 1'b1;
          end
        end
      end
    end
  end

  assign kb.outASCIIData = ascii_q;
  assign kb.outWriteData = wr_q;
  assign outScanCode     = scan_q;
  assign outFrameError   = frame_err_q;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames (device-to-host), decodes Set 2 scan codes, and produces the `outASCIIData`/`outWriteData` stream consumed by the LCD message writer. It is the producing end of that interface. It emits printable ASCII 0x20–0x7E and the control codes the writer acts on: up 0x11, down 0x12, left 0x13, right 0x14, Enter 0x0D, Escape 0x1B. It sits between the board PS/2 pins and the LCD top level, in the same `inClock` domain.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, default 50000: number of `inClock` cycles without a filtered falling edge, mid-frame, that aborts the frame (1 ms at 50 MHz).
- `inClock`  input  1  system clock, 50 MHz.
- `inResetNeg`  input  1  reset, asynchronous, active-low; clock `inClock`.
- `PS2_CLK`  input  1  raw keyboard clock, asynchronous.
- `PS2_DAT`  input  1  raw keyboard data, asynchronous.
- `outASCIIData`  output  8  decoded character or control code; held until the next decode.
- `outWriteData`  output  1  one-cycle strobe marking `outASCIIData` as new.
- `outScanCode`  output  8  last accepted frame byte, including prefixes; debug only.
- `outFrameError`  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.

## Operation
- Synchronizer: `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchronizer.
- Clock filter:
  - A counter tracks how long the synchronized clock has differed from the filtered clock.
  - The filtered clock takes the new level only after `FILTER_LEN` consecutive differing samples.
  - A filtered 1→0 transition produces a one-cycle `fall` pulse. Synchronized data is sampled in that cycle.
- Frame FSM:
  - IDLE: a `fall` with data 0 (start bit) moves to DATA. A `fall` with data 1 is ignored.
  - DATA: shifts 8 bits in, LSB first, with a 3-bit counter. After bit 7, moves to PARITY.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: the frame is valid iff stop bit = 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Valid → `byte_rdy` pulse. Invalid → `outFrameError`. Either way, return to IDLE.
  - In DATA, PARITY or STOP, the timeout counter clears on every `fall`. If it reaches `TIMEOUT`: return to IDLE, pulse `outFrameError`, no byte. The counter is held at 0 in IDLE.
- Decoder, acting on `byte_rdy`:
  - `outScanCode` ← byte.
  - 0xE0 sets `ext`. 0xF0 sets `brk`. No output for either.
  - Any other byte clears `ext` and `brk` after it is processed.
  - Shift tracking: non-extended 0x12 (left) and 0x59 (right) make/break set/clear `lshift`/`rshift`; no output. `shift = lshift | rshift`. Extended 0x12/0x59 are ignored.
  - `brk` set on any other code: no output.
  - Extended make codes: 0x75→0x11, 0x72→0x12, 0x6B→0x13, 0x74→0x14, 0x5A→0x0D. Every other extended code produces no output.
  - Non-extended controls: 0x5A→0x0D, 0x76→0x1B, 0x29→0x20.
  - Letters, Set 2 codes a..z = 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. Lowercase when `shift`=0, uppercase when `shift`=1.
  - Digits: 0x45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9'. Shifted → `)!@#$%^&*(`.
  - Punctuation, unshifted/shifted: 0x4E `-`/`_`, 0x55 `=`/`+`, 0x41 `,`/`<`, 0x49 `.`/`>`, 0x4A `/`/`?`, 0x4C `;`/`:`, 0x52 `'`/`"`.
  - Any other code: no output. Flags clear as normal.
- Typematic repeats arrive as repeated make codes. Each one produces its own strobe.
- An error frame clears `ext` and `brk`. It leaves the shift state unchanged.

## Timing
- Reset values: `outASCIIData`=0x00, `outWriteData`=0, `outScanCode`=0x00, `outFrameError`=0. FSM in IDLE; all counters, `ext`, `brk`, `lshift`, `rshift` = 0.
- Reset asserted mid-frame: the partial frame is discarded with no strobe. After release the FSM waits for a fresh start bit.
- Input to `fall` latency: 2 sync cycles + `FILTER_LEN` cycles.
- `byte_rdy` fires in the cycle the STOP-state `fall` is processed. `outASCIIData` updates and `outWriteData` is high in the next cycle, for exactly 1 cycle.
- `outFrameError` is high 1 cycle after the bad stop `fall`, or 1 cycle after the timeout count is reached.
- Glitches shorter than `FILTER_LEN` cycles on `PS2_CLK` produce no edge.
- Consecutive strobes are at least one full frame apart (more than 10 PS/2 bit periods). The LCD writer's edge detect therefore always sees a 0 between strobes.

## Test plan
- Frame 0x1C with correct parity → one `outWriteData` pulse, `outASCIIData`=0x61, `outFrameError`=0.
- Frames 12, 1C, F0 1C, F0 12, 1C → 0x41 then 0x61. Exactly 2 strobes; no strobe for shift or break frames.
- Frames E0 75, E0 F0 75, E0 6B, 76 → 0x11, 0x13, 0x1B. Exactly 3 strobes.
- Frame 0x1C with wrong parity → `outFrameError` pulse, no `outWriteData`. The next valid 0x1C still yields 0x61.
- Start bit plus 4 data bits, then `PS2_CLK` held high for `TIMEOUT`+10 cycles → `outFrameError` pulse, FSM in IDLE. A following 0x29 frame yields 0x20.
- 3-cycle low glitches on `PS2_CLK` while idle → no state change. Reset asserted mid-frame → all outputs 0, and the next valid frame decodes correctly.
